// File: rtl/predistort_stream_merge.sv
// Packet-level round-robin merger: multiplexes NUM_CHANNELS AXI streams onto
// one registered output stream, whole packets at a time, tagging every beat
// with its source channel. Keeps a 32-bit packet counter per channel.
module predistort_stream_merge #(
    parameter int WIDTH        = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int CHAN_W       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [NUM_CHANNELS*WIDTH-1:0] i_tdata,
    input  logic [NUM_CHANNELS-1:0]       i_tlast,
    input  logic [NUM_CHANNELS-1:0]       i_tvalid,
    output logic [NUM_CHANNELS-1:0]       i_tready,
    output logic [WIDTH-1:0]              o_tdata,
    output logic                          o_tlast,
    output logic [CHAN_W-1:0]             o_tchan,
    output logic                          o_tvalid,
    input  logic                          o_tready,
    input  logic [CHAN_W-1:0]             cnt_sel,
    output logic [31:0]                   cnt_data
);

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [CHAN_W-1:0] grant, grant_next;
    logic [CHAN_W-1:0] ptr, ptr_next;
    logic [CHAN_W-1:0] scan_chan;
    logic              scan_found;
    logic              sel_valid;
    logic              sel_last;
    logic [WIDTH-1:0]  sel_data;
    logic              out_free;
    logic              accept;
    logic [31:0]       pkt_cnt [NUM_CHANNELS];

    // Route the granted channel's beat to the output side.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; a missing default infers a latch.
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (grant == CHAN_W'(c)) begin
                sel_valid = i_tvalid[c];
                sel_last  = i_tlast[c];
                sel_data  = i_tdata[c*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin search: lowest valid channel at or above ptr wins, else the
    // lowest valid channel below ptr (the wrapped part of the scan).
    always_comb begin
        scan_found = 1'b0;
        scan_chan  = '0;
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (i_tvalid[c] && (CHAN_W'(c) < ptr)) begin
                scan_found = 1'b1;
                scan_chan  = CHAN_W'(c);
            end
        end
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (i_tvalid[c] && (CHAN_W'(c) >= ptr)) begin
                scan_found = 1'b1;
                scan_chan  = CHAN_W'(c);
            end
        end
    end

    // Output register can take a beat when empty or draining this cycle;
    // nothing is accepted in a clear cycle so no beat is silently lost.
    assign out_free = !o_tvalid || o_tready;
    assign accept   = (state == PASS) && sel_valid && out_free && !clear;

    // Only the granted channel ever sees ready, and only in PASS.
    always_comb begin
        i_tready = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            i_tready[c] = (state == PASS) && out_free && !clear && (grant == CHAN_W'(c));
        end
    end

    // Next-state logic: grant in IDLE, release the output on an accepted tlast.
    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (scan_found) begin
                    state_next = PASS;
                    grant_next = scan_chan;
                end
            end
            PASS: begin
                if (accept && sel_last) begin
                    state_next = IDLE;
                    ptr_next   = (grant == CHAN_W'(NUM_CHANNELS - 1)) ? '0 : grant + CHAN_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else if (clear) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            ptr   <= ptr_next;
        end
    end

    // Output register: load on accept, drop valid on a drain with no refill,
    // otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
            o_tchan  <= '0;
        end else if (clear) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
            o_tchan  <= '0;
        end else if (accept) begin
            o_tvalid <= 1'b1;
            o_tdata  <= sel_data;
            o_tlast  <= sel_last;
            o_tchan  <= grant;
        end else if (o_tready) begin
            o_tvalid <= 1'b0;
        end
    end

    // Per-channel packet counters, bumped when a packet's last beat is taken.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: this array is software-visible status, so every entry is
        // reset; a plain data buffer would be left unreset.
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) pkt_cnt[c] <= '0;
        end else if (clear) begin
            for (int c = 0; c < NUM_CHANNELS; c++) pkt_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (accept && sel_last && (grant == CHAN_W'(c))) begin
                    pkt_cnt[c] <= pkt_cnt[c] + 32'd1;
                end
            end
        end
    end

    // Counter readback; unused select codes read as zero.
    always_comb begin
        cnt_data = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (cnt_sel == CHAN_W'(c)) cnt_data = pkt_cnt[c];
        end
    end

endmodule

// File: tb/tb_predistort_stream_merge.sv
// Self-checking bench for predistort_stream_merge: a per-cycle vector table
// for latency/backpressure, then directed and randomized packet traffic
// checked against per-channel packet scoreboards.
module tb_predistort_stream_merge;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic [N*W-1:0]  i_tdata;
    logic [N-1:0]    i_tlast;
    logic [N-1:0]    i_tvalid;
    logic [N-1:0]    i_tready;
    logic [W-1:0]    o_tdata;
    logic            o_tlast;
    logic [CW-1:0]   o_tchan;
    logic            o_tvalid;
    logic            o_tready;
    logic [CW-1:0]   cnt_sel;
    logic [31:0]     cnt_data;

    predistort_stream_merge #(.WIDTH(W), .NUM_CHANNELS(N), .CHAN_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tchan  (o_tchan),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .cnt_sel  (cnt_sel),
        .cnt_data (cnt_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input int c, input logic [31:0] exp);
        cnt_sel = CW'(c);
        #1;
        check($sformatf("cnt_ch%0d", c), cnt_data, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0]  tvalid;
        logic [N-1:0]  tlast;
        logic [N*W-1:0] tdata;
        logic          ordy;
        logic          e_ovalid;
        logic [W-1:0]  e_odata;
        logic          e_olast;
        logic [CW-1:0] e_ochan;
        logic [N-1:0]  e_irdy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [N*W-1:0] mk(input int ch, input logic [W-1:0] d);
        logic [N*W-1:0] r;
        for (int c = 0; c < N; c++) r[c*W +: W] = (c == ch) ? d : (16'hBE00 + 16'(c));
        return r;
    endfunction

    function automatic vec_t row(input logic [N-1:0] tv, input logic [N-1:0] tl,
                                 input logic [N*W-1:0] td, input logic rdy,
                                 input logic eov, input logic [W-1:0] eod,
                                 input logic eol, input logic [CW-1:0] eoc,
                                 input logic [N-1:0] eir);
        vec_t v;
        v.tvalid = tv; v.tlast = tl; v.tdata = td; v.ordy = rdy;
        v.e_ovalid = eov; v.e_odata = eod; v.e_olast = eol; v.e_ochan = eoc; v.e_irdy = eir;
        return v;
    endfunction

    // ---------------- packet engine + scoreboard ----------------
    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           gap;
    } beat_t;

    typedef struct {
        int           chan;
        logic [W-1:0] data;
        logic         last;
        int           cyc;
    } obeat_t;

    beat_t  src_q [N][$];
    beat_t  exp_q [N][$];
    obeat_t out_log[$];
    int     st_chan[$];
    int     st_cyc[$];
    int     st_prev_end[$];

    bit           cur_v [N];
    bit           gap_loaded [N];
    int           gap_cnt [N];
    int           acc_cnt [N];
    logic [31:0]  cnt_model [N];
    int           vprob = 100;
    int           rprob = 100;
    int           cyc = 0;
    bit           in_pkt = 0;
    int           pkt_chan = 0;
    bit           prev_stall = 0;
    logic [W+CW:0] prev_out;

    task automatic add_pkt(input int c, input int len, input logic [W-1:0] base,
                           input int gap_at, input int gap_len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = base + W'(i);
            b.last = (i == len - 1);
            b.gap  = (i == gap_at) ? gap_len : 0;
            src_q[c].push_back(b);
        end
    endtask

    // One clock: drive sources at negedge, sample just after, commit at posedge.
    task automatic cycle(input bit do_clear, input bit rdy_low);
        logic [N-1:0]  in_acc;
        bit            out_acc;
        logic [W-1:0]  od;
        logic          ol;
        logic [CW-1:0] oc;
        beat_t         b;
        @(negedge clk);
        clear = do_clear;
        for (int c = 0; c < N; c++) begin
            if (!cur_v[c] && src_q[c].size() > 0) begin
                if (!gap_loaded[c]) begin
                    gap_cnt[c]    = src_q[c][0].gap;
                    gap_loaded[c] = 1'b1;
                end
                if (gap_cnt[c] > 0) gap_cnt[c]--;
                else if ($urandom_range(99) < vprob) cur_v[c] = 1'b1;
            end
            i_tvalid[c]       = cur_v[c];
            i_tdata[c*W +: W] = cur_v[c] ? src_q[c][0].data : W'($urandom);
            i_tlast[c]        = cur_v[c] ? src_q[c][0].last : 1'($urandom);
        end
        o_tready = rdy_low ? 1'b0 : ($urandom_range(99) < rprob);
        #1;
        if (prev_stall) begin
            check("stall_valid_held", o_tvalid, 1'b1);
            check("stall_beat_held", {o_tchan, o_tlast, o_tdata}, prev_out);
        end
        check("ready_onehot0", ($countones(i_tready) <= 1), 1'b1);
        in_acc     = i_tvalid & i_tready;
        out_acc    = o_tvalid && o_tready && !clear;
        prev_stall = o_tvalid && !o_tready && !clear;
        prev_out   = {o_tchan, o_tlast, o_tdata};
        od = o_tdata; ol = o_tlast; oc = o_tchan;
        @(posedge clk);
        cyc++;
        for (int c = 0; c < N; c++) begin
            if (in_acc[c]) begin
                b = src_q[c].pop_front();
                exp_q[c].push_back(b);
                cur_v[c]      = 1'b0;
                gap_loaded[c] = 1'b0;
                acc_cnt[c]++;
                if (b.last) cnt_model[c] = cnt_model[c] + 32'd1;
            end
        end
        if (out_acc) begin
            out_log.push_back('{chan: int'(oc), data: od, last: ol, cyc: cyc});
            if (in_pkt) check("no_interleave", oc, pkt_chan);
            in_pkt   = !ol;
            pkt_chan = int'(oc);
            if (exp_q[oc].size() == 0) begin
                check("out_beat_expected", 0, 1);
            end else begin
                b = exp_q[oc].pop_front();
                check("out_data", od, b.data);
                check("out_last", ol, b.last);
            end
        end
    endtask

    task automatic drain(input int max_cycles, input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cycles && !done; k++) begin
            cycle(1'b0, 1'b0);
            done = 1'b1;
            for (int c = 0; c < N; c++)
                if (src_q[c].size() != 0 || exp_q[c].size() != 0) done = 1'b0;
        end
        check({name, "_drained"}, done, 1'b1);
        repeat (2) cycle(1'b0, 1'b0);
    endtask

    task automatic build_starts();
        st_chan.delete(); st_cyc.delete(); st_prev_end.delete();
        for (int i = 0; i < out_log.size(); i++) begin
            if (i == 0 || out_log[i-1].last) begin
                st_chan.push_back(out_log[i].chan);
                st_cyc.push_back(out_log[i].cyc);
                st_prev_end.push_back((i == 0) ? -1 : out_log[i-1].cyc);
            end
        end
    endtask

    task automatic flush_model();
        for (int c = 0; c < N; c++) begin
            src_q[c].delete(); exp_q[c].delete();
            cur_v[c] = 1'b0; gap_loaded[c] = 1'b0; gap_cnt[c] = 0;
            cnt_model[c] = '0;
        end
        in_pkt = 1'b0; prev_stall = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc;
        bit seen;
        vec_t v;

        reset = 1'b1; clear = 1'b0; i_tvalid = '0; i_tlast = '0; i_tdata = '0;
        o_tready = 1'b0; cnt_sel = '0;
        flush_model();
        for (int c = 0; c < N; c++) acc_cnt[c] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_ovalid", o_tvalid, 1'b0);
        check("rst_odata", o_tdata, '0);
        check("rst_olast", o_tlast, 1'b0);
        check("rst_ochan", o_tchan, '0);
        check("rst_irdy", i_tready, '0);
        for (int c = 0; c < N; c++) check_cnt(c, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ch2 4-beat packet, o_tready=1: one bubble then 1 beat/cycle
        vecs.push_back(row(4'b0100, 4'b0000, mk(2, 16'h0010), 1, 0, 16'h0, 0, 0, 4'b0000));
        vecs.push_back(row(4'b0100, 4'b0000, mk(2, 16'h0010), 1, 0, 16'h0, 0, 0, 4'b0100));
        vecs.push_back(row(4'b0100, 4'b0000, mk(2, 16'h0011), 1, 1, 16'h0010, 0, 2, 4'b0100));
        vecs.push_back(row(4'b0100, 4'b0000, mk(2, 16'h0012), 1, 1, 16'h0011, 0, 2, 4'b0100));
        vecs.push_back(row(4'b0100, 4'b0100, mk(2, 16'h0013), 1, 1, 16'h0012, 0, 2, 4'b0100));
        vecs.push_back(row(4'b0000, 4'b0000, mk(2, 16'h0000), 1, 1, 16'h0013, 1, 2, 4'b0000));
        vecs.push_back(row(4'b0000, 4'b0000, mk(2, 16'h0000), 1, 0, 16'h0, 0, 0, 4'b0000));
        // ch1 3-beat packet (ptr=3 wraps to ch1), o_tready 1,0,0,1
        vecs.push_back(row(4'b0010, 4'b0000, mk(1, 16'h1230), 1, 0, 16'h0, 0, 0, 4'b0000));
        vecs.push_back(row(4'b0010, 4'b0000, mk(1, 16'h1230), 1, 0, 16'h0, 0, 0, 4'b0010));
        vecs.push_back(row(4'b0010, 4'b0000, mk(1, 16'h1231), 0, 1, 16'h1230, 0, 1, 4'b0000));
        vecs.push_back(row(4'b0010, 4'b0000, mk(1, 16'h1231), 0, 1, 16'h1230, 0, 1, 4'b0000));
        vecs.push_back(row(4'b0010, 4'b0000, mk(1, 16'h1231), 1, 1, 16'h1230, 0, 1, 4'b0010));
        vecs.push_back(row(4'b0010, 4'b0010, mk(1, 16'h1232), 1, 1, 16'h1231, 0, 1, 4'b0010));
        vecs.push_back(row(4'b0000, 4'b0000, mk(1, 16'h0000), 1, 1, 16'h1232, 1, 1, 4'b0000));
        vecs.push_back(row(4'b0000, 4'b0000, mk(1, 16'h0000), 1, 0, 16'h0, 0, 0, 4'b0000));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            i_tvalid = v.tvalid; i_tlast = v.tlast; i_tdata = v.tdata; o_tready = v.ordy;
            #1;
            check($sformatf("vec%0d_ovalid", i), o_tvalid, v.e_ovalid);
            check($sformatf("vec%0d_irdy", i), i_tready, v.e_irdy);
            if (v.e_ovalid) begin
                check($sformatf("vec%0d_odata", i), o_tdata, v.e_odata);
                check($sformatf("vec%0d_olast", i), o_tlast, v.e_olast);
                check($sformatf("vec%0d_ochan", i), o_tchan, v.e_ochan);
            end
        end
        check_cnt(0, 32'd0);
        check_cnt(1, 32'd1);
        check_cnt(2, 32'd1);
        check_cnt(3, 32'd0);

        // Idle clear pulse resets counters and pointer
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        #1;
        check("clr_ovalid", o_tvalid, 1'b0);
        for (int c = 0; c < N; c++) check_cnt(c, 32'd0);

        // Fairness: all channels valid, two 2-beat packets each
        vprob = 100; rprob = 100; out_log.delete();
        for (int c = 0; c < N; c++) begin
            add_pkt(c, 2, 16'(16'h1000 * c + 16'h0100), -1, 0);
            add_pkt(c, 2, 16'(16'h1000 * c + 16'h0200), -1, 0);
        end
        drain(200, "fair");
        build_starts();
        check("fair_npkts", st_chan.size(), 8);
        for (int k = 0; k < st_chan.size() && k < 8; k++) begin
            check($sformatf("fair_order%0d", k), st_chan[k], k % N);
            if (k > 0) check($sformatf("fair_bubble%0d", k), st_cyc[k] - st_prev_end[k], 2);
        end
        for (int c = 0; c < N; c++) check_cnt(c, 32'd2);

        // Non-interleave: ch0 drops valid 3 cycles mid-packet while ch3 waits
        out_log.delete();
        add_pkt(0, 5, 16'h0A00, 2, 3);
        add_pkt(3, 2, 16'h3A00, -1, 0);
        drain(200, "nonint");
        build_starts();
        check("nonint_npkts", st_chan.size(), 2);
        if (st_chan.size() == 2) begin
            check("nonint_first", st_chan[0], 0);
            check("nonint_second", st_chan[1], 3);
            check("nonint_len0", out_log[4].last, 1'b1);
        end

        // Wrap and single-beat: ch2 sets ptr=3, then ch0/ch3 single beats
        add_pkt(2, 1, 16'h2B00, -1, 0);
        drain(100, "wrap_pre");
        out_log.delete();
        add_pkt(0, 1, 16'h0B01, -1, 0);
        add_pkt(0, 1, 16'h0B02, -1, 0);
        add_pkt(3, 1, 16'h3B01, -1, 0);
        add_pkt(3, 1, 16'h3B02, -1, 0);
        drain(100, "wrap");
        build_starts();
        check("wrap_npkts", st_chan.size(), 4);
        for (int k = 0; k < st_chan.size() && k < 4; k++) begin
            check($sformatf("wrap_order%0d", k), st_chan[k], (k % 2 == 0) ? 3 : 0);
            if (k > 0) check($sformatf("wrap_gap%0d", k), st_cyc[k] - st_prev_end[k], 2);
        end
        for (int c = 0; c < N; c++) check_cnt(c, cnt_model[c]);

        // Clear mid-packet: ch1 5 beats, clear while beat 2 is presented
        add_pkt(1, 5, 16'h1C00, -1, 0);
        base_acc = acc_cnt[1];
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            cycle(1'b0, 1'b0);
            if (acc_cnt[1] == base_acc + 1) seen = 1'b1;
        end
        check("clrmid_first_beat", seen, 1'b1);
        cycle(1'b1, 1'b1);
        flush_model();
        out_log.delete();
        @(negedge clk);
        clear = 1'b0; i_tvalid = '0; o_tready = 1'b1;
        #1;
        check("clrmid_ovalid", o_tvalid, 1'b0);
        check("clrmid_irdy", i_tready, '0);
        for (int c = 0; c < N; c++) check_cnt(c, 32'd0);
        add_pkt(1, 2, 16'h1D00, -1, 0);
        add_pkt(0, 2, 16'h0D00, -1, 0);
        drain(100, "clrmid");
        build_starts();
        check("clrmid_npkts", st_chan.size(), 2);
        if (st_chan.size() > 0) check("clrmid_ch0_first", st_chan[0], 0);

        // Randomized traffic with varying valid/ready density
        for (int ph = 0; ph < 3; ph++) begin
            vprob = (ph == 0) ? 100 : (ph == 1) ? 60 : 30;
            rprob = (ph == 0) ? 100 : (ph == 1) ? 50 : 80;
            for (int c = 0; c < N; c++) begin
                for (int p = 0; p < 15; p++) begin
                    add_pkt(c, int'($urandom_range(1, 5)), W'($urandom),
                            int'($urandom_range(0, 4)),
                            ($urandom_range(9) == 0) ? int'($urandom_range(1, 3)) : 0);
                end
            end
            drain(6000, $sformatf("rand%0d", ph));
            for (int c = 0; c < N; c++) check_cnt(c, cnt_model[c]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
